// File: rtl/pcpi_mul_arbiter_if.sv
// pcpi_mul_arbiter_if: bundles the two requester PCPI channels (r0_*, r1_*) and the
// shared multiplier channel (m_*) used by pcpi_mul_arbiter.
//   slave  : arbiter view - takes requests and multiplier results, drives responses and m_*.
//   master : environment view - drives requests and multiplier results.
interface pcpi_mul_arbiter_if;
    logic        r0_valid, r1_valid;
    logic [31:0] r0_insn, r0_rs1, r0_rs2;
    logic [31:0] r1_insn, r1_rs1, r1_rs2;
    logic        r0_wr, r0_wait, r0_ready;
    logic        r1_wr, r1_wait, r1_ready;
    logic [31:0] r0_rd, r1_rd;
    logic        m_valid;
    logic [31:0] m_insn, m_rs1, m_rs2;
    logic        m_wr, m_wait, m_ready;
    logic [31:0] m_rd;

    modport slave (
        input  r0_valid, r0_insn, r0_rs1, r0_rs2,
        input  r1_valid, r1_insn, r1_rs1, r1_rs2,
        output r0_wr, r0_rd, r0_wait, r0_ready,
        output r1_wr, r1_rd, r1_wait, r1_ready,
        output m_valid, m_insn, m_rs1, m_rs2,
        input  m_wr, m_rd, m_wait, m_ready
    );

    modport master (
        output r0_valid, r0_insn, r0_rs1, r0_rs2,
        output r1_valid, r1_insn, r1_rs1, r1_rs2,
        input  r0_wr, r0_rd, r0_wait, r0_ready,
        input  r1_wr, r1_rd, r1_wait, r1_ready,
        input  m_valid, m_insn, m_rs1, m_rs2,
        output m_wr, m_rd, m_wait, m_ready
    );
endinterface

// File: rtl/pcpi_mul_arbiter.sv
// pcpi_mul_arbiter: shares one PCPI multiplier between two requesters with round-robin
// grant and an unclaimed-instruction timeout.
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   bus    : requester channels r0_*/r1_* and multiplier channel m_* (slave modport)
module pcpi_mul_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    pcpi_mul_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_n;
    logic          grant, rr_ptr, hold, res_wr;
    logic [CW-1:0] cnt;
    logic [31:0]   res_rd, l_insn, l_rs1, l_rs2;
    logic          elig0, elig1, pick, timeout, resp0, resp1;

    always_comb begin
        // the requester just served is masked for one IDLE cycle so its late-dropping valid is not re-granted
        elig0   = bus.r0_valid && !(hold && !grant);
        elig1   = bus.r1_valid && !(hold && grant);
        pick    = (elig0 && elig1) ? rr_ptr : elig1;
        timeout = !bus.m_wait && cnt == CW'(TIMEOUT - 1);
        state_n = (state == IDLE) ? ((elig0 || elig1) ? BUSY : IDLE) :
                  (state == BUSY) ? ((bus.m_ready || timeout) ? RESP : BUSY) : IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant  <= 1'b0;
            rr_ptr <= 1'b0;
            hold   <= 1'b0;
            cnt    <= '0;
            res_wr <= 1'b0;
            res_rd <= '0;
            l_insn <= '0;
            l_rs1  <= '0;
            l_rs2  <= '0;
        end else begin
            hold <= state == RESP;
            if (state == IDLE && (elig0 || elig1)) begin
                grant  <= pick;
                rr_ptr <= !pick;
                cnt    <= '0;
                l_insn <= pick ? bus.r1_insn : bus.r0_insn;
                l_rs1  <= pick ? bus.r1_rs1 : bus.r0_rs1;
                l_rs2  <= pick ? bus.r1_rs2 : bus.r0_rs2;
            end
            if (state == BUSY) begin
                // any cycle the multiplier claims the instruction restarts the timeout window
                cnt <= bus.m_wait ? '0 : cnt + 1'b1;
                if (bus.m_ready || timeout) begin
                    res_wr <= bus.m_ready && bus.m_wr;
                    res_rd <= bus.m_ready ? bus.m_rd : '0;
                end
            end
        end
    end

    assign resp0 = state == RESP && !grant;
    assign resp1 = state == RESP && grant;

    assign bus.m_valid  = state == BUSY;
    assign bus.m_insn   = l_insn;
    assign bus.m_rs1    = l_rs1;
    assign bus.m_rs2    = l_rs2;

    assign bus.r0_ready = resp0;
    assign bus.r0_wr    = resp0 && res_wr;
    assign bus.r0_rd    = resp0 ? res_rd : '0;
    assign bus.r1_ready = resp1;
    assign bus.r1_wr    = resp1 && res_wr;
    assign bus.r1_rd    = resp1 ? res_rd : '0;

    // wait is a pure function of the request; gating with resetn keeps every output low in reset
    assign bus.r0_wait  = resetn && bus.r0_valid && !resp0;
    assign bus.r1_wait  = resetn && bus.r1_valid && !resp1;
endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// tb_pcpi_mul_arbiter: directed and randomized checks of pcpi_mul_arbiter against a behavioural reference model.
module tb_pcpi_mul_arbiter;
    localparam int TMO = 16;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          passed = 0;
    int          total = 0;
    int          mcnt = 0;
    int          mdl_lat = 4;
    bit          mdl_wait = 1'b0;
    bit          mdl_silent = 1'b0;
    bit          mdl_force = 1'b0;
    bit          mdl_late = 1'b0;
    logic [31:0] mdl_frd = '0;
    int          last_g = 1;
    op_t         q0[$];
    op_t         q1[$];

    pcpi_mul_arbiter_if bus ();

    pcpi_mul_arbiter #(.TIMEOUT(TMO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 10'd0, f3, 5'd1, 7'b0110011};
    endfunction

    // RV32M semantics: MUL low word, MULH signed high word, MULHU unsigned high word
    function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] u, s;
        u = {32'd0, a} * {32'd0, b};
        s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return insn[14:12] == 3'd0 ? u[31:0] : insn[14:12] == 3'd1 ? s[63:32] : u[63:32];
    endfunction

    function automatic op_t rnd_op();
        int k;
        k = $urandom_range(0, 2);
        return {mk(k == 2 ? 3'd3 : 3'(k)), 32'($urandom), 32'($urandom)};
    endfunction

    // multiplier model: responds mdl_lat cycles after m_valid, optionally claiming with m_wait meanwhile
    always @(negedge clk) begin
        if (mdl_late) begin
            mcnt        <= 0;
            bus.m_wait  <= 1'b0;
            bus.m_ready <= 1'b1;
            bus.m_wr    <= 1'b1;
            bus.m_rd    <= 32'hDEAD_BEEF;
        end else if (bus.m_valid && !mdl_silent) begin
            mcnt        <= mcnt + 1;
            bus.m_wait  <= mdl_wait;
            bus.m_ready <= mcnt + 1 == mdl_lat;
            bus.m_wr    <= mcnt + 1 == mdl_lat;
            bus.m_rd    <= mcnt + 1 == mdl_lat ? (mdl_force ? mdl_frd : mul_ref(bus.m_insn, bus.m_rs1, bus.m_rs2)) : 32'd0;
        end else begin
            mcnt        <= 0;
            bus.m_wait  <= 1'b0;
            bus.m_ready <= 1'b0;
            bus.m_wr    <= 1'b0;
            bus.m_rd    <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.r0_valid = v; bus.r0_insn = i; bus.r0_rs1 = a; bus.r0_rs2 = b;
        end else begin
            bus.r1_valid = v; bus.r1_insn = i; bus.r1_rs1 = a; bus.r1_rs2 = b;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        last_g = 1;
    endtask

    // one request from requester n with the other idle; expectations from the current model settings
    task automatic do_req(input int n, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        int          cyc, en;
        logic        ewr, seen;
        logic [31:0] erd;
        if (mdl_silent || (!mdl_wait && mdl_lat > TMO)) begin
            en = TMO + 1; ewr = 1'b0; erd = '0;
        end else begin
            en = mdl_lat + 1; ewr = 1'b1; erd = mdl_force ? mdl_frd : mul_ref(insn, a, b);
        end
        set_req(n, 1'b1, insn, a, b);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("m_valid_after_grant", 32'(bus.m_valid), 1);
                chk("m_rs1_latched", bus.m_rs1, a);
                chk("wait_while_busy", 32'(n ? bus.r1_wait : bus.r0_wait), 1);
                set_req(n, 1'b1, 32'($urandom), 32'($urandom), 32'($urandom));
            end
            seen = n ? bus.r1_ready : bus.r0_ready;
        end
        chk("latency", cyc, en);
        chk("wr", 32'(n ? bus.r1_wr : bus.r0_wr), 32'(ewr));
        chk("rd", n ? bus.r1_rd : bus.r0_rd, erd);
        chk("own_wait_in_resp", 32'(n ? bus.r1_wait : bus.r0_wait), 0);
        chk("other_ready", 32'(n ? bus.r0_ready : bus.r1_ready), 0);
        chk("other_wr", 32'(n ? bus.r0_wr : bus.r1_wr), 0);
        chk("other_rd", n ? bus.r0_rd : bus.r1_rd, 0);
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(n ? bus.r1_ready : bus.r0_ready), 0);
        @(posedge clk); #1;
        chk("hold_masks_late_valid", 32'(bus.m_valid), 0);
        set_req(n, 1'b0, '0, '0, '0);
        last_g = n;
    endtask

    // both requesters work through q0/q1; serve order and cycle of each response predicted from the queues
    task automatic contend();
        int   cyc, exp_c, who;
        logic e0, e1;
        op_t  o0, o1;
        who = (q0.size() != 0 && q1.size() != 0) ? 1 - last_g : (q0.size() != 0 ? 0 : 1);
        exp_c = mdl_lat + 1;
        if (q0.size() != 0) begin o0 = q0[0]; set_req(0, 1'b1, o0.insn, o0.a, o0.b); end
        if (q1.size() != 0) begin o1 = q1[0]; set_req(1, 1'b1, o1.insn, o1.a, o1.b); end
        cyc = 0;
        while (q0.size() + q1.size() > 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            e0 = cyc == exp_c && who == 0;
            e1 = cyc == exp_c && who == 1;
            chk("r0_ready", 32'(bus.r0_ready), 32'(e0));
            chk("r1_ready", 32'(bus.r1_ready), 32'(e1));
            chk("r0_wr", 32'(bus.r0_wr), 32'(e0));
            chk("r1_wr", 32'(bus.r1_wr), 32'(e1));
            chk("r0_wait", 32'(bus.r0_wait), 32'(bus.r0_valid && !e0));
            chk("r1_wait", 32'(bus.r1_wait), 32'(bus.r1_valid && !e1));
            chk("r0_rd", bus.r0_rd, e0 ? mul_ref(q0[0].insn, q0[0].a, q0[0].b) : 32'd0);
            chk("r1_rd", bus.r1_rd, e1 ? mul_ref(q1[0].insn, q1[0].a, q1[0].b) : 32'd0);
            if (cyc == exp_c) begin
                if (who == 0) begin
                    void'(q0.pop_front());
                    if (q0.size() != 0) begin o0 = q0[0]; set_req(0, 1'b1, o0.insn, o0.a, o0.b); end
                    else set_req(0, 1'b0, '0, '0, '0);
                end else begin
                    void'(q1.pop_front());
                    if (q1.size() != 0) begin o1 = q1[0]; set_req(1, 1'b1, o1.insn, o1.a, o1.b); end
                    else set_req(1, 1'b0, '0, '0, '0);
                end
                last_g = who;
                who = (who == 0 ? q1.size() != 0 : q0.size() == 0) ? 1 : 0;
                exp_c = cyc + mdl_lat + (who == last_g ? 3 : 2);
            end
        end
        chk("contend_done", q0.size() + q1.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        set_req(0, 1'b1, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_insn", bus.m_insn, 0);
        chk("rst_m_rs1", bus.m_rs1, 0);
        chk("rst_m_rs2", bus.m_rs2, 0);
        chk("rst_r0_wait", 32'(bus.r0_wait), 0);
        chk("rst_r0_ready", 32'(bus.r0_ready), 0);
        chk("rst_r0_rd", bus.r0_rd, 0);
        chk("rst_r1_ready", 32'(bus.r1_ready), 0);
        set_req(0, 1'b0, '0, '0, '0);
        resetn = 1'b1;
        @(posedge clk); #1;

        mdl_lat = 4;
        do_req(0, mk(3'd0), 32'd3, 32'd7);

        do_reset();
        mdl_lat = 3;
        q0.push_back({mk(3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        q1.push_back({mk(3'd0), 32'hFFFF_FFFD, 32'd7});
        contend();

        mdl_lat = 2;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(rnd_op());
            q1.push_back(rnd_op());
        end
        contend();

        mdl_silent = 1'b1;
        do_req(0, mk(3'd0), 32'($urandom), 32'($urandom));
        mdl_silent = 1'b0;

        mdl_wait = 1'b1; mdl_lat = 100; mdl_force = 1'b1; mdl_frd = 32'h3E8;
        do_req(0, mk(3'd0), 32'd10, 32'd100);
        mdl_wait = 1'b0; mdl_force = 1'b0;

        mdl_lat = TMO;
        do_req(1, mk(3'd1), 32'($urandom), 32'($urandom));
        mdl_lat = TMO + 1;
        do_req(1, mk(3'd0), 32'($urandom), 32'($urandom));

        for (int i = 0; i < 6; i++) begin
            op_t o;
            o = rnd_op();
            mdl_lat = $urandom_range(1, 20);
            mdl_wait = 1'($urandom_range(0, 1));
            do_req($urandom_range(0, 1), o.insn, o.a, o.b);
        end
        mdl_wait = 1'b0;

        for (int r = 0; r < 2; r++) begin
            mdl_lat = $urandom_range(1, 8);
            mdl_wait = 1'($urandom_range(0, 1));
            for (int i = $urandom_range(1, 3); i > 0; i--) q0.push_back(rnd_op());
            for (int i = $urandom_range(1, 3); i > 0; i--) q1.push_back(rnd_op());
            contend();
        end
        mdl_wait = 1'b0;

        mdl_lat = 50;
        set_req(0, 1'b1, mk(3'd0), 32'd5, 32'd6);
        set_req(1, 1'b1, mk(3'd0), 32'd8, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_reset", 32'(bus.m_valid), 1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_m_valid", 32'(bus.m_valid), 0);
        chk("rst_mid_m_insn", bus.m_insn, 0);
        chk("rst_mid_m_rs1", bus.m_rs1, 0);
        chk("rst_mid_r0_wait", 32'(bus.r0_wait), 0);
        chk("rst_mid_r1_wait", 32'(bus.r1_wait), 0);
        chk("rst_mid_r0_ready", 32'(bus.r0_ready), 0);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        last_g = 1;
        mdl_late = 1'b1;
        @(posedge clk); #1;
        mdl_late = 1'b0;
        chk("late_ready_no_busy", 32'(bus.m_valid), 0);
        @(posedge clk); #1;
        chk("late_ready_r0_ignored", 32'(bus.r0_ready), 0);
        chk("late_ready_r1_ignored", 32'(bus.r1_ready), 0);
        mdl_lat = 3;
        do_req(0, mk(3'd3), 32'($urandom), 32'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pcpi_mul_arbiter.md
PCPI_MUL_ARBITER -- requirements
Module: pcpi_mul_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the m_wait-low BUSY cycles before an unclaimed-instruction response.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports rN_valid  input  1  requester N (N=0,1) PCPI instruction valid.
REQ-005 SHALL have ports rN_insn  input  32  requester N instruction word.
REQ-006 SHALL have ports rN_rs1  input  32  requester N operand 1.
REQ-007 SHALL have ports rN_rs2  input  32  requester N operand 2.
REQ-008 SHALL have ports rN_wr  output  1  requester N result-write flag, valid with rN_ready.
REQ-009 SHALL have ports rN_rd  output  32  requester N result, valid with rN_ready, else 0.
REQ-010 SHALL have ports rN_wait  output  1  requester N hold-off (suppresses core timeout).
REQ-011 SHALL have ports rN_ready  output  1  requester N one-cycle completion strobe.
REQ-012 SHALL have port m_valid  output  1  valid to the shared multiplier.
REQ-013 SHALL have ports m_insn, m_rs1, m_rs2  output  32 each  latched instruction/operands to the multiplier.
REQ-014 SHALL have port m_wr  input  1  multiplier write flag.
REQ-015 SHALL have port m_rd  input  32  multiplier result.
REQ-016 SHALL have port m_wait  input  1  multiplier busy/claim indication.
REQ-017 SHALL have port m_ready  input  1  multiplier completion strobe.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP plus registers grant (1b), rr_ptr (1b), hold (1b), cnt ($clog2(TIMEOUT)+1 bits), res_wr, res_rd.
REQ-019 IDLE: eligible requesters = rN_valid and not (hold and N==grant); none -> stay IDLE.
REQ-020 IDLE, one eligible: grant it; both eligible: grant rr_ptr; on the granting edge latch rN_insn/rs1/rs2, clear cnt, go BUSY.
REQ-021 rr_ptr SHALL be set to ~grant on each grant, so consecutive contention alternates r0, r1, r0.
REQ-022 m_valid SHALL be 1 exactly while in BUSY; m_insn/m_rs1/m_rs2 SHALL drive latched values at all times (0 after reset).
REQ-023 BUSY: m_ready=1 sampled -> capture res_wr=m_wr, res_rd=m_rd, go RESP (m_ready wins over timeout on the same edge).
REQ-024 BUSY: m_wait=1 -> cnt cleared; m_wait=0 -> cnt increments; cnt reaching TIMEOUT-1 with m_ready=0 -> res_wr=0, res_rd=0, go RESP.
REQ-025 RESP lasts one cycle: r[grant]_ready=1, r[grant]_wr=res_wr, r[grant]_rd=res_rd; then IDLE with hold=1.
REQ-026 hold SHALL clear after one IDLE cycle, masking the just-served requester's late-dropping valid for exactly one cycle.
REQ-027 rN_wait SHALL be 1 when rN_valid=1 and not (state==RESP and grant==N), covering both the granted and the pending requester.
REQ-028 Non-granted requester SHALL see rN_ready=0, rN_wr=0, rN_rd=0 at all times.
REQ-029 Latency: grant edge -> m_valid next cycle; m_ready edge -> rN_ready next cycle; overhead 2 cycles over multiplier latency.
REQ-030 Operands SHALL NOT change while BUSY even if rN_rs1/rs2 inputs change.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE, grant=0, rr_ptr=0, hold=0, cnt=0, res_*=0, latched operands 0, all outputs 0, regardless of state.
REQ-032 A multiplier result arriving after reset mid-BUSY SHALL be ignored (m_ready in IDLE has no effect).

Verification
REQ-033 r0 MUL rs1=3 rs2=7, model ready 4 cycles later wr=1 rd=21 -> r0_ready one cycle, r0_wr=1, r0_rd=21, r1 outputs all 0.
REQ-034 r0 and r1 valid same cycle after reset (r0 MULHU FFFFFFFF*FFFFFFFF, r1 MUL -3*7) -> r0 served first rd=FFFFFFFE, then r1 rd=FFFFFFEB; r1_wait=1 throughout.
REQ-035 Both requesters held valid for three ops -> grant order r0, r1, r0; no requester served twice consecutively.
REQ-036 Model never asserts m_wait/m_ready, TIMEOUT=16 -> r0_ready exactly 16 cycles after m_valid rises, r0_wr=0, r0_rd=0.
REQ-037 Model holds m_wait=1 for 100 cycles then ready rd=0x3E8 -> no timeout, r0_rd=0x3E8.
REQ-038 resetn pulsed low mid-BUSY -> m_valid and all rN_* outputs 0 immediately; late m_ready ignored; next request served normally.
